spi_xfer_sequencer: RTL and testbench
=====================================

SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame length in bits (2..16).
REQ-002 SHALL have parameter DIV, default 2, SCLK half-period in CLK cycles (>=1).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port CLR  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CONTROL  input  8  [0] enable, [1] abort, [5] clear sticky flags, others ignored.
REQ-006 SHALL have port WRITE  input  1  one-cycle strobe loading DATA_IN into TX buffer.
REQ-007 SHALL have port DATA_IN  input  WIDTH  transmit word.
REQ-008 SHALL have port READ  input  1  one-cycle strobe consuming RX buffer.
REQ-009 SHALL have port DATA_OUT  output  WIDTH  RX buffer contents.
REQ-010 SHALL have port STATUS  output  8  [0] busy, [1] TX full, [2] RX full, [3] overrun (sticky), [4] write collision (sticky), [7] TX empty, others 0.
REQ-011 SHALL have ports SCLK output 1, MOSI output 1, MISO input 1, SS_N output 1 (SPI mode 0 bus).

Function
REQ-012 SHALL implement FSM IDLE, LOAD, SHIFT, DONE.
REQ-013 WRITE with TX buffer empty: TX buffer captures DATA_IN, TX full next cycle; WRITE with TX full: data dropped, STATUS[4] set.
REQ-014 IDLE->LOAD when CONTROL[0]=1 and TX full; LOAD lasts 1 cycle: shift reg <= TX buffer, TX buffer empties, SS_N driven low, MOSI = shift reg MSB.
REQ-015 SHIFT: SCLK toggles every DIV cycles starting low; MISO sampled on each SCLK rising edge; shift reg shifts left, next MOSI bit driven on each falling edge; MSB first.
REQ-016 SHIFT SHALL last exactly 2*DIV*WIDTH cycles, ending with SCLK low after the WIDTH-th falling edge.
REQ-017 DONE lasts 1 cycle: received word -> RX buffer, RX full set; if RX already full and no READ that cycle, word overwrites and STATUS[3] set.
REQ-018 READ in same cycle as DONE write: new word stored, RX full stays 1, no overrun.
REQ-019 READ with RX full clears RX full next cycle; READ with RX empty ignored.
REQ-020 DONE->LOAD when CONTROL[0]=1 and TX full (SS_N stays low, back-to-back frame); else DONE->IDLE, SS_N high.
REQ-021 CONTROL[1]=1 in any state: next cycle IDLE, SS_N high, SCLK low, shift reg and partial RX discarded, TX/RX buffers kept.
REQ-022 CONTROL[0]=0 mid-frame SHALL NOT stop the current frame; it only blocks the next LOAD.
REQ-023 CONTROL[5]=1 clears STATUS[3] and STATUS[4] next cycle; a simultaneous set event wins.
REQ-024 STATUS[0]=1 whenever FSM not IDLE; STATUS[7]=~STATUS[1].

Reset
REQ-025 CLR=1 at a clock edge: FSM IDLE, SCLK 0, MOSI 0, SS_N 1, DATA_OUT 0, TX/RX buffers empty, all STATUS flags 0 except STATUS[7]=1, counters 0; overrides all other inputs including mid-frame.

Configuration
REQ-026 With SPI_SEQ_LOOPBACK_EN defined, sampled data SHALL be MOSI instead of MISO (MISO ignored); without it, MISO sampled; bus outputs identical in both builds.

Structure
REQ-027 Shared package spi_pkg SHALL hold the FSM state enum and CONTROL/STATUS bit-index constants.
REQ-028 SCLK edge timing SHALL be a sub-module spi_clk_div (DIV counter emitting rise/fall strobes, cleared by CLR or abort).

Verification
REQ-029 WIDTH=8, DIV=2: WRITE 0xA5, CONTROL=0x01, MISO drives 0x3C -> MOSI 1,0,1,0,0,1,0,1 on rising edges, SHIFT 32 cycles, DATA_OUT=0x3C, STATUS[2]=1, SS_N high after DONE.
REQ-030 Second WRITE 0x5A during first frame -> DONE->LOAD, SS_N never rises between frames, both words transmitted.
REQ-031 Two frames without READ -> STATUS[3]=1, DATA_OUT=second word; CONTROL=0x21 one cycle -> STATUS[3]=0.
REQ-032 WRITE 0x11 then WRITE 0x22 while TX full and CONTROL[0]=0 -> STATUS[4]=1, transmitted word 0x11.
REQ-033 CONTROL[1] pulsed after 3 SCLK rises -> IDLE next cycle, SS_N=1, SCLK=0, STATUS[2] unchanged; CLR mid-frame -> all REQ-025 values next cycle.
REQ-034 SPI_SEQ_LOOPBACK_EN build, MISO tied 0, WRITE 0xC3 -> DATA_OUT=0xC3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM state encoding and
// the CONTROL / STATUS bit positions used by the host interface.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } spi_state_e;

    // CONTROL bit positions
    localparam int unsigned CTL_EN        = 0;
    localparam int unsigned CTL_ABORT     = 1;
    localparam int unsigned CTL_CLR_FLAGS = 5;

    // STATUS bit positions
    localparam int unsigned STS_BUSY     = 0;
    localparam int unsigned STS_TX_FULL  = 1;
    localparam int unsigned STS_RX_FULL  = 2;
    localparam int unsigned STS_OVERRUN  = 3;
    localparam int unsigned STS_WCOL     = 4;
    localparam int unsigned STS_TX_EMPTY = 7;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK edge timer: counts DIV system clocks per SCLK half-period while run is
// high and emits one-cycle rise/fall strobes. Idles with SCLK phase low.
module spi_clk_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          tick;

    assign tick = run && (cnt_q == CW'(DIV - 1));
    assign rise = tick && !phase_q;
    assign fall = tick && phase_q;

    // Next count/phase: held at zero/low whenever not running
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// SPI mode-0 master transfer sequencer with single-word TX and RX buffers,
// back-to-back framing, abort and sticky overrun / write-collision flags.
// Build option: define SPI_SEQ_LOOPBACK_EN to sample MOSI instead of MISO.
module spi_xfer_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [7:0]       CONTROL,
    input  logic             WRITE,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             READ,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic [7:0]       STATUS,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO,
    output logic             SS_N
);

    localparam int unsigned BCW = $clog2(WIDTH);

    spi_state_e       state_q, state_d;
    logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic             tx_full_q, tx_full_d;
    logic [WIDTH-1:0] rx_buf_q, rx_buf_d;
    logic             rx_full_q, rx_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             ss_n_q, ss_n_d;
    logic             ovr_q, ovr_d;
    logic             wcol_q, wcol_d;

    logic en, abort, clr_flags, ovr_set, wcol_set, sample;
    logic sclk_rise, sclk_fall;
    logic ctrl_unused;

    assign en        = CONTROL[CTL_EN];
    assign abort     = CONTROL[CTL_ABORT];
    assign clr_flags = CONTROL[CTL_CLR_FLAGS];

`ifdef SPI_SEQ_LOOPBACK_EN
    assign sample      = mosi_q;
    assign ctrl_unused = ^{CONTROL[7:6], CONTROL[4:2], MISO};
`else
    assign sample      = MISO;
    assign ctrl_unused = ^{CONTROL[7:6], CONTROL[4:2]};
`endif

    spi_clk_div #(
        .DIV(DIV)
    ) u_clk_div (
        .clk (CLK),
        .clr (CLR || abort),
        .run (state_q == ST_SHIFT),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    // Next-state logic: host buffers first, then FSM actions which may override
    always_comb begin
        state_d   = state_q;
        tx_buf_d  = tx_buf_q;
        tx_full_d = tx_full_q;
        rx_buf_d  = rx_buf_q;
        rx_full_d = rx_full_q;
        shift_d   = shift_q;
        rx_sh_d   = rx_sh_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;
        ovr_set   = 1'b0;
        wcol_set  = 1'b0;

        if (WRITE) begin
            if (tx_full_q) begin
                wcol_set = 1'b1;
            end else begin
                tx_buf_d  = DATA_IN;
                tx_full_d = 1'b1;
            end
        end

        if (READ && rx_full_q) begin
            rx_full_d = 1'b0;
        end

        if (abort) begin
            state_d   = ST_IDLE;
            ss_n_d    = 1'b1;
            sclk_d    = 1'b0;
            mosi_d    = 1'b0;
            shift_d   = '0;
            rx_sh_d   = '0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && tx_full_q) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // LOAD is only reachable with the TX buffer full, so a
                    // same-cycle WRITE has already been flagged as a collision
                    shift_d   = tx_buf_q;
                    tx_full_d = 1'b0;
                    ss_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = tx_buf_q[WIDTH-1];
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[WIDTH-2:0], sample};
                    end
                    if (sclk_fall) begin
                        sclk_d    = 1'b0;
                        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                        mosi_d    = shift_q[WIDTH-2];
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BCW'(WIDTH - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Overrides the READ clear above: a read in this cycle
                    // consumes the old word and the new one lands cleanly
                    rx_buf_d  = rx_sh_q;
                    rx_full_d = 1'b1;
                    if (rx_full_q && !READ) begin
                        ovr_set = 1'b1;
                    end
                    if (en && tx_full_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        ss_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        ovr_d  = (ovr_q && !clr_flags) || ovr_set;
        wcol_d = (wcol_q && !clr_flags) || wcol_set;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= ST_IDLE;
            tx_buf_q  <= '0;
            tx_full_q <= 1'b0;
            rx_buf_q  <= '0;
            rx_full_q <= 1'b0;
            shift_q   <= '0;
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            ovr_q     <= 1'b0;
            wcol_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_buf_q  <= tx_buf_d;
            tx_full_q <= tx_full_d;
            rx_buf_q  <= rx_buf_d;
            rx_full_q <= rx_full_d;
            shift_q   <= shift_d;
            rx_sh_q   <= rx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            ovr_q     <= ovr_d;
            wcol_q    <= wcol_d;
        end
    end

    // Status word assembly from registered flags
    always_comb begin
        STATUS               = '0;
        STATUS[STS_BUSY]     = (state_q != ST_IDLE);
        STATUS[STS_TX_FULL]  = tx_full_q;
        STATUS[STS_RX_FULL]  = rx_full_q;
        STATUS[STS_OVERRUN]  = ovr_q;
        STATUS[STS_WCOL]     = wcol_q;
        STATUS[STS_TX_EMPTY] = !tx_full_q;
    end

    assign DATA_OUT = rx_buf_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign SS_N     = ss_n_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: a transaction-level SPI slave
// and buffer/flag model, directed scenarios plus randomized frames.
module tb_spi_xfer_sequencer;

    localparam int W = 8;
    localparam int D = 2;
    localparam int FRAME_LOW = 2 * D * W + 1;

    logic         clk = 1'b0;
    logic         clr;
    logic [7:0]   control;
    logic         write;
    logic [W-1:0] din;
    logic         read;
    logic [W-1:0] dout;
    logic [7:0]   status;
    logic         sclk, mosi, miso, ss_n;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(.WIDTH(W), .DIV(D)) dut (
        .CLK(clk), .CLR(clr), .CONTROL(control), .WRITE(write),
        .DATA_IN(din), .READ(read), .DATA_OUT(dout), .STATUS(status),
        .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS_N(ss_n)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI slave / bus monitor ----------------
    logic [W-1:0] slave_q[$];
    logic [W-1:0] mosi_q[$];
    int           lowlen_q[$];
    logic [W-1:0] cur_slave = '0;
    logic [W-1:0] mosi_word = '0;
    logic [W-1:0] head;
    int           rises = 0;
    int           lowcnt = 0;
    logic         prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (ss_n) begin
            if (lowcnt > 0) lowlen_q.push_back(lowcnt);
            lowcnt = 0;
            rises  = 0;
        end else begin
            lowcnt++;
            if (sclk && !prev_sclk) begin
                if (rises == 0) cur_slave = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
                mosi_word = {mosi_word[W-2:0], mosi};
                rises++;
                if (rises == W) begin
                    mosi_q.push_back(mosi_word);
                    rises = 0;
                end
            end
        end
        prev_sclk = sclk;
        head = (slave_q.size() > 0) ? slave_q[0] : '0;
`ifdef SPI_SEQ_LOOPBACK_EN
        miso = 1'b0;
`else
        miso = (rises == 0) ? head[W-1] : cur_slave[W-1-rises];
`endif
    end

    // ---------------- transaction-level model ----------------
    logic         m_rx_full = 1'b0;
    logic         m_ovr = 1'b0;
    logic [W-1:0] m_rx_data = '0;

    function automatic logic [W-1:0] exp_rx(input logic [W-1:0] tx, input logic [W-1:0] slv);
`ifdef SPI_SEQ_LOOPBACK_EN
        return tx;
`else
        return slv;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [W-1:0] d);
        write = 1'b1;
        din   = d;
        tick();
        write = 1'b0;
    endtask

    task automatic do_read();
        read = 1'b1;
        tick();
        read = 1'b0;
        m_rx_full = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!status[0] && t < 20) begin tick(); t++; end
        check("frame_start", {31'd0, status[0]}, 32'd1);
        t = 0;
        while (status[0] && t < 5000) begin tick(); t++; end
        check("frame_end", {31'd0, status[0]}, 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_rises(input int n, input string tag);
        int t = 0;
        while (rises != n && t < 500) begin tick(); t++; end
        check(tag, rises, n);
    endtask

    task automatic model_frame(input logic [W-1:0] tx, input logic [W-1:0] slv);
        if (m_rx_full) m_ovr = 1'b1;
        m_rx_full = 1'b1;
        m_rx_data = exp_rx(tx, slv);
        if (mosi_q.size() > 0) check("mosi_word", mosi_q.pop_front(), tx);
        else check("mosi_word_missing", 0, 1);
    endtask

    task automatic check_after(input int exp_low);
        if (lowlen_q.size() > 0) check("ssn_low_len", lowlen_q.pop_front(), exp_low);
        else check("ssn_low_missing", 0, 1);
        check("data_out", dout, m_rx_data);
        check("rx_full", status[2], m_rx_full);
        check("overrun", status[3], m_ovr);
        check("ss_n_idle", ss_n, 1);
        check("sclk_idle", sclk, 0);
    endtask

    task automatic run_single(input logic [W-1:0] tx, input logic [W-1:0] slv, input bit rd);
        if (rd) do_read();
        slave_q.push_back(slv);
        do_write(tx);
        wait_done();
        model_frame(tx, slv);
        check_after(FRAME_LOW);
    endtask

    task automatic flush_monitor();
        tick();
        tick();
        slave_q.delete();
        mosi_q.delete();
        lowlen_q.delete();
    endtask

    initial begin
        clr = 1'b1; control = '0; write = 1'b0; read = 1'b0; din = '0;
        tick(); tick(); tick();
        // reset values
        check("rst_status", status, 8'h80);
        check("rst_dout", dout, 0);
        check("rst_ss_n", ss_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        clr = 1'b0;
        control = 8'h01;
        tick();

        // single frame A5 / 3C
        run_single(8'hA5, 8'h3C, 1'b0);
        do_read();
        check("rx_cleared", status[2], 0);

        // back-to-back frames, second written mid-frame, no read -> overrun
        slave_q.push_back(8'h96);
        slave_q.push_back(8'h69);
        do_write(8'hA5);
        begin
            int t = 0;
            while (!(status[7] && status[0]) && t < 50) begin tick(); t++; end
            check("tx_emptied", {30'd0, status[7], status[0]}, 32'd3);
        end
        do_write(8'h5A);
        wait_done();
        model_frame(8'hA5, 8'h96);
        model_frame(8'h5A, 8'h69);
        check_after(2 * FRAME_LOW + 1);
        check("lowlen_single_period", lowlen_q.size(), 0);

        // clear sticky flags
        control = 8'h21;
        tick();
        control = 8'h01;
        m_ovr = 1'b0;
        check("ovr_cleared", status[3], 0);

        // write collision while disabled
        control = 8'h00;
        do_write(8'h11);
        do_write(8'h22);
        check("wcol_set", status[4], 1);
        check("tx_full", status[1], 1);
        control = 8'h20;
        tick();
        control = 8'h00;
        check("wcol_cleared", status[4], 0);
        slave_q.push_back(8'hE7);
        control = 8'h01;
        wait_done();
        model_frame(8'h11, 8'hE7);
        check_after(FRAME_LOW);

        // C3 frame (loopback build returns C3)
        run_single(8'hC3, 8'h5C, 1'b1);

        // randomized frames
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                control = 8'h21;
                tick();
                control = 8'h01;
                m_ovr = 1'b0;
                check("rand_ovr_clr", status[3], 0);
            end
            run_single(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
        end

        // abort after three SCLK rises; TX and RX buffers survive
        slave_q.push_back(8'h81);
        do_write(8'h3E);
        begin
            int t = 0;
            while (!status[7] && t < 50) begin tick(); t++; end
        end
        do_write(8'h77);
        wait_rises(3, "abort_rises");
        control = 8'h02;
        tick();
        control = 8'h00;
        check("abort_ss_n", ss_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", status[0], 0);
        check("abort_rx_full", status[2], m_rx_full);
        check("abort_dout", dout, m_rx_data);
        check("abort_tx_kept", status[1], 1);
        flush_monitor();

        // CLR mid-frame
        slave_q.push_back(8'h42);
        control = 8'h01;
        wait_rises(3, "clr_rises");
        clr = 1'b1;
        tick();
        check("clr_status", status, 8'h80);
        check("clr_dout", dout, 0);
        check("clr_ss_n", ss_n, 1);
        check("clr_sclk", sclk, 0);
        check("clr_mosi", mosi, 0);
        clr = 1'b0;
        tick();
        tick();
        check("clr_stays_idle", status[0], 0);
        flush_monitor();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
